// File: rtl/vga_scaled_display.sv
// VGA timing plus upscaled, double-buffered framebuffer readout on one pixel clock.
// Optional build macro VGA_TEST_PATTERN_EN adds a test_mode input selecting internal colour bars.
module vga_scaled_display #(
  parameter int H_ACTIVE    = 640,
  parameter int H_FP        = 16,
  parameter int H_SYNC      = 96,
  parameter int H_BP        = 48,
  parameter int V_ACTIVE    = 480,
  parameter int V_FP        = 10,
  parameter int V_SYNC      = 2,
  parameter int V_BP        = 33,
  parameter int SCALE_SHIFT = 2,
  parameter int PIX_W       = 3,
  parameter int ADDR_WIDTH  = 15,
  parameter int RD_LATENCY  = 1,
  parameter int SYNC_POL    = 0
) (
  input  logic                  clk_25,
  input  logic                  reset,
  input  logic                  swap_req,
`ifdef VGA_TEST_PATTERN_EN
  input  logic                  test_mode,
`endif
  output logic                  swap_ack,
  output logic                  buf_sel,
  output logic [ADDR_WIDTH:0]   rd_addr,
  input  logic [PIX_W-1:0]      rd_data,
  output logic [PIX_W-1:0]      rgb,
  output logic                  hs,
  output logic                  vs,
  output logic                  bright,
  output logic [9:0]            h_count,
  output logic [9:0]            v_count,
  output logic                  frame_start
);
  localparam int STAGES = RD_LATENCY + 2;
  localparam logic [9:0] H_LAST  = 10'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
  localparam logic [9:0] V_LAST  = 10'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
  localparam logic [9:0] H_ACT_C = 10'(H_ACTIVE);
  localparam logic [9:0] V_ACT_C = 10'(V_ACTIVE);
  localparam logic [9:0] HS_BEG  = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] HS_END  = 10'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [9:0] VS_BEG  = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] VS_END  = 10'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [9:0] V_MASK  = 10'((1 << SCALE_SHIFT) - 1);
  localparam logic [ADDR_WIDTH-1:0] SRC_W = ADDR_WIDTH'(H_ACTIVE >> SCALE_SHIFT);
  localparam logic ACT_LVL = 1'(SYNC_POL);

  typedef struct packed {
    logic act;
    logic hs;
    logic vs;
`ifdef VGA_TEST_PATTERN_EN
    logic [PIX_W-1:0] pat;
`endif
  } stage_t;

  logic [9:0]            h_nxt, v_nxt;
  logic                  h_wrap, v_wrap;
  logic [ADDR_WIDTH-1:0] line_base, offset;
  logic                  swap_req_d, pending, req_edge, at_swap;
  stage_t                raw;
  stage_t                vld_pipe [STAGES-1:0];
  logic [PIX_W-1:0]      src_pix;

  always_comb begin
    h_wrap   = (h_count == H_LAST);
    v_wrap   = (v_count == V_LAST);
    h_nxt    = h_wrap ? 10'd0 : h_count + 10'd1;
    v_nxt    = v_count;
    if (h_wrap) v_nxt = v_wrap ? 10'd0 : v_count + 10'd1;
    offset   = line_base + ADDR_WIDTH'(h_count >> SCALE_SHIFT);
    raw      = '0;
    raw.act  = (h_count < H_ACT_C) && (v_count < V_ACT_C);
    raw.hs   = (h_count >= HS_BEG) && (h_count < HS_END);
    raw.vs   = (v_count >= VS_BEG) && (v_count < VS_END);
`ifdef VGA_TEST_PATTERN_EN
    raw.pat  = PIX_W'(h_count / 10'(H_ACTIVE / 8));
    src_pix  = test_mode ? vld_pipe[STAGES-2].pat : rd_data;
`else
    src_pix  = rd_data;
`endif
    req_edge = swap_req && !swap_req_d;
    at_swap  = (h_count == 10'd0) && (v_count == V_ACT_C);
  end

  // line_base tracks (v>>SCALE_SHIFT)*SRC_W; it advances when the next line starts a new source row
  always_ff @(posedge clk_25) begin
    if (reset) begin
      h_count     <= '0;
      v_count     <= '0;
      line_base   <= '0;
      rd_addr     <= '0;
      frame_start <= 1'b0;
    end else begin
      h_count     <= h_nxt;
      v_count     <= v_nxt;
      frame_start <= (h_nxt == 10'd0) && (v_nxt == 10'd0);
      rd_addr     <= {buf_sel, raw.act ? offset : '0};
      if (h_wrap) begin
        if (v_nxt == 10'd0)                line_base <= '0;
        else if ((v_nxt & V_MASK) == 10'd0) line_base <= line_base + SRC_W;
      end
    end
  end

  // Swap only at the first blanking line so buf_sel is stable for the whole visible frame
  always_ff @(posedge clk_25) begin
    if (reset) begin
      swap_req_d <= 1'b0;
      pending    <= 1'b0;
      buf_sel    <= 1'b0;
      swap_ack   <= 1'b0;
    end else begin
      swap_req_d <= swap_req;
      swap_ack   <= 1'b0;
      if (at_swap && (pending || req_edge)) begin
        buf_sel  <= ~buf_sel;
        swap_ack <= 1'b1;
        pending  <= 1'b0;
      end else if (req_edge) begin
        pending  <= 1'b1;
      end
    end
  end

  // Delay line: stage STAGES-2 lines up with rd_data, rgb register adds the last clock
  always_ff @(posedge clk_25) begin
    if (reset) begin
      for (int i = 0; i < STAGES; i++) vld_pipe[i] <= '0;
      rgb <= '0;
    end else begin
      vld_pipe[0] <= raw;
      for (int i = 1; i < STAGES; i++) vld_pipe[i] <= vld_pipe[i-1];
      rgb <= vld_pipe[STAGES-2].act ? src_pix : '0;
    end
  end

  assign bright = vld_pipe[STAGES-1].act;
  assign hs     = vld_pipe[STAGES-1].hs ? ACT_LVL : ~ACT_LVL;
  assign vs     = vld_pipe[STAGES-1].vs ? ACT_LVL : ~ACT_LVL;

endmodule

// File: tb/tb_vga_scaled_display.sv
// Directed bench for vga_scaled_display on a shrunken 64x48 raster (80x55 total) to keep runs short.
module tb_vga_scaled_display;
  localparam int HA = 64, HF = 4, HSW = 8, HB = 4;
  localparam int VA = 48, VF = 2, VSW = 2, VB = 3;
  localparam int HT = HA + HF + HSW + HB;   // 80
  localparam int VT = VA + VF + VSW + VB;   // 55
  localparam int FRAME = HT * VT;           // 4400
  localparam int AW = 15;

  logic          clk_25 = 1'b0;
  logic          reset, swap_req;
  logic          swap_ack, buf_sel, hs, vs, bright, frame_start;
  logic [AW:0]   rd_addr;
  logic [2:0]    rd_data, rgb;
  logic [9:0]    h_count, v_count;
`ifdef VGA_TEST_PATTERN_EN
  logic          test_mode;
`endif

  int n_err = 0, n_chk = 0, ack_cnt = 0;

  vga_scaled_display #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HSW), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VSW), .V_BP(VB),
    .SCALE_SHIFT(2), .PIX_W(3), .ADDR_WIDTH(AW), .RD_LATENCY(1), .SYNC_POL(0)
  ) dut (
    .clk_25(clk_25), .reset(reset), .swap_req(swap_req),
`ifdef VGA_TEST_PATTERN_EN
    .test_mode(test_mode),
`endif
    .swap_ack(swap_ack), .buf_sel(buf_sel), .rd_addr(rd_addr), .rd_data(rd_data),
    .rgb(rgb), .hs(hs), .vs(vs), .bright(bright),
    .h_count(h_count), .v_count(v_count), .frame_start(frame_start)
  );

  always #5 clk_25 = ~clk_25;

  // one-clock-latency RAM whose contents are the low address bits
  always @(posedge clk_25) rd_data <= rd_addr[2:0];
  always @(posedge clk_25) if (swap_ack === 1'b1) ack_cnt++;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic wait_cnt(input int h, input int v);
    int n = 0;
    while (!(h_count == 10'(h) && v_count == 10'(v))) begin
      @(negedge clk_25);
      n++;
      if (n > 2 * FRAME) begin
        chk($sformatf("timeout_wait_%0d_%0d", h, v), 32'(n), 32'(2 * FRAME));
        return;
      end
    end
  endtask

  task automatic check_reset_state(input string tag);
    chk({tag, "_h"}, 32'(h_count), 0);
    chk({tag, "_v"}, 32'(v_count), 0);
    chk({tag, "_addr"}, 32'(rd_addr), 0);
    chk({tag, "_rgb"}, 32'(rgb), 0);
    chk({tag, "_bright"}, 32'(bright), 0);
    chk({tag, "_hs"}, 32'(hs), 1);
    chk({tag, "_vs"}, 32'(vs), 1);
    chk({tag, "_bufsel"}, 32'(buf_sel), 0);
    chk({tag, "_ack"}, 32'(swap_ack), 0);
    chk({tag, "_fs"}, 32'(frame_start), 0);
  endtask

  typedef struct {
    int         h;
    int         v;
    int         off;
    logic [2:0] rgb;
    logic       br;
  } vec_t;
  vec_t vecs [10];

  initial begin
    int n, ack0;
    // SRC_W = 16; offsets worked out by hand, rgb = offset[2:0] in active video
    vecs[0] = '{0, 0, 0, 3'd0, 1'b1};
    vecs[1] = '{4, 0, 1, 3'd1, 1'b1};
    vecs[2] = '{63, 0, 15, 3'd7, 1'b1};
    vecs[3] = '{64, 0, 0, 3'd0, 1'b0};
    vecs[4] = '{3, 1, 0, 3'd0, 1'b1};
    vecs[5] = '{0, 4, 16, 3'd0, 1'b1};
    vecs[6] = '{20, 5, 21, 3'd5, 1'b1};
    vecs[7] = '{8, 9, 34, 3'd2, 1'b1};
    vecs[8] = '{63, 47, 191, 3'd7, 1'b1};
    vecs[9] = '{0, 48, 0, 3'd0, 1'b0};

    reset = 1'b1; swap_req = 1'b0;
`ifdef VGA_TEST_PATTERN_EN
    test_mode = 1'b0;
`endif
    repeat (3) @(negedge clk_25);
    check_reset_state("rst");
    reset = 1'b0;

    // frame_start period
    n = 0;
    while (frame_start !== 1'b1 && n < 2 * FRAME) begin @(negedge clk_25); n++; end
    chk("fs_at_h", 32'(h_count), 0);
    chk("fs_at_v", 32'(v_count), 0);
    n = 0;
    do begin @(negedge clk_25); n++; end while (frame_start !== 1'b1 && n < 2 * FRAME);
    chk("fs_period", 32'(n), FRAME);

    // address / pixel vectors within one frame
    for (int i = 0; i < 10; i++) begin
      wait_cnt(vecs[i].h, vecs[i].v);
      @(negedge clk_25);
      chk($sformatf("addr_%0d", i), 32'(rd_addr), 32'(vecs[i].off));
      repeat (2) @(negedge clk_25);
      chk($sformatf("rgb_%0d", i), 32'(rgb), 32'(vecs[i].rgb));
      chk($sformatf("bright_%0d", i), 32'(bright), 32'(vecs[i].br));
      chk($sformatf("hs_%0d", i), 32'(hs), 1);
      chk($sformatf("vs_%0d", i), 32'(vs), 1);
    end

    // hs: raw 68..75, seen 3 clocks later, period 80
    n = 0;
    while (hs !== 1'b0 && n < 2 * FRAME) begin @(negedge clk_25); n++; end
    chk("hs_fall_h", 32'(h_count), HA + HF + 3);
    n = 0;
    while (hs === 1'b0 && n < 2 * FRAME) begin @(negedge clk_25); n++; end
    chk("hs_width", 32'(n), HSW);
    while (hs !== 1'b0 && n < 2 * FRAME) begin @(negedge clk_25); n++; end
    chk("hs_period", 32'(n), HT);
    // vs: raw lines 50..51
    n = 0;
    while (vs !== 1'b0 && n < 2 * FRAME) begin @(negedge clk_25); n++; end
    chk("vs_fall_v", 32'(v_count), VA + VF);
    chk("vs_fall_h", 32'(h_count), 3);
    n = 0;
    while (vs === 1'b0 && n < 2 * FRAME) begin @(negedge clk_25); n++; end
    chk("vs_width", 32'(n), VSW * HT);

    // single pulse swap
    ack0 = ack_cnt;
    wait_cnt(0, 10);
    swap_req = 1'b1; @(negedge clk_25); swap_req = 1'b0;
    wait_cnt(0, VA);
    chk("sw1_pre_bufsel", 32'(buf_sel), 0);
    @(negedge clk_25);
    chk("sw1_bufsel", 32'(buf_sel), 1);
    chk("sw1_ack", 32'(swap_ack), 1);
    @(negedge clk_25);
    chk("sw1_ack_drop", 32'(swap_ack), 0);
    wait_cnt(4, 0);
    @(negedge clk_25);
    chk("sw1_addr_msb", 32'(rd_addr), 32'((1 << AW) | 1));
    chk("sw1_ack_count", 32'(ack_cnt - ack0), 1);

    // level held across three frames
    ack0 = ack_cnt;
    wait_cnt(0, 10);
    swap_req = 1'b1;
    repeat (3 * FRAME) @(negedge clk_25);
    swap_req = 1'b0;
    wait_cnt(0, VA + 1);
    chk("lvl_ack_count", 32'(ack_cnt - ack0), 1);
    chk("lvl_bufsel", 32'(buf_sel), 0);

    // edge coincident with the swap cycle
    wait_cnt(0, VA);
    swap_req = 1'b1;
    @(negedge clk_25);
    chk("coin_ack", 32'(swap_ack), 1);
    chk("coin_bufsel", 32'(buf_sel), 1);
    swap_req = 1'b0;

    // reset mid-frame drops a pending swap
    wait_cnt(0, 15);
    swap_req = 1'b1; @(negedge clk_25); swap_req = 1'b0;
    wait_cnt(0, 20);
    reset = 1'b1;
    @(negedge clk_25);
    check_reset_state("mid_rst");
    reset = 1'b0;
    ack0 = ack_cnt;
    wait_cnt(2, VA);
    chk("mid_rst_no_swap", 32'(ack_cnt - ack0), 0);
    chk("mid_rst_bufsel", 32'(buf_sel), 0);

`ifdef VGA_TEST_PATTERN_EN
    // bar width 8: pixel 8 is bar 1, pixel 56 is bar 7
    test_mode = 1'b1;
    wait_cnt(8, 0);
    repeat (3) @(negedge clk_25);
    chk("pat_bar1", 32'(rgb), 1);
    wait_cnt(56, 0);
    repeat (3) @(negedge clk_25);
    chk("pat_bar7", 32'(rgb), 7);
    chk("pat_bright", 32'(bright), 1);
    test_mode = 1'b0;
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #(10 * 90000);
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end
endmodule
